// File: rtl/fpu_rand_dispatcher_if.sv
// Request-side and FPU-side handshake bundle for fpu_rand_dispatcher.
// The master modport is the dispatcher's view; slave is the surrounding fabric.
interface fpu_rand_dispatcher_if #(
    parameter int NB_FPU     = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [DATA_WIDTH-1:0] req_data_i;
    logic [NB_FPU-1:0]     fpu_req_valid_o;
    logic [NB_FPU-1:0]     fpu_req_ready_i;
    logic [DATA_WIDTH-1:0] fpu_req_data_o;
    logic [NB_FPU-1:0]     fpu_done_i;

    modport master (
        input  req_valid_i, req_data_i, fpu_req_ready_i, fpu_done_i,
        output req_ready_o, fpu_req_valid_o, fpu_req_data_o
    );

    modport slave (
        output req_valid_i, req_data_i, fpu_req_ready_i, fpu_done_i,
        input  req_ready_o, fpu_req_valid_o, fpu_req_data_o
    );
endinterface

// File: rtl/fpu_rand_dispatcher.sv
// Steers requests to NB_FPU shared FPUs starting at the LFSR-preferred index, with credit tracking.
// Optional stall-cycle counter enabled by defining FPU_RAND_DISPATCHER_PERF_EN.
module fpu_rand_dispatcher #(
    parameter int NB_FPU     = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rand_addr_i,
    output logic                  lfsr_en_o,
    fpu_rand_dispatcher_if.master bus,
    output logic [NB_FPU-1:0]     busy_o,
    output logic                  err_o,
    output logic [31:0]           stall_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTST);
    localparam logic [NB_FPU-1:0]    ONE_HOT = {{(NB_FPU-1){1'b0}}, 1'b1};

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] tgt;
    logic [ADDR_WIDTH-1:0] sel;
    logic [NB_FPU-1:0]     elig;
    logic [NB_FPU-1:0]     inc;
    logic [NB_FPU-1:0]     valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]  cnt [NB_FPU];
    logic                  any_elig;
    logic                  drain;
    logic                  req_ready;
    logic                  accept;

    always_comb begin
        elig   = '0;
        busy_o = '0;
        for (int i = 0; i < NB_FPU; i++) begin
            elig[i]   = (cnt[i] < MAX_CNT);
            busy_o[i] = (cnt[i] == MAX_CNT);
        end
    end

    // Walk downward so the closest eligible index above rand_addr_i wins.
    always_comb begin
        sel = rand_addr_i;
        for (int k = NB_FPU - 1; k >= 0; k--) begin
            if (elig[rand_addr_i + ADDR_WIDTH'(k)])
                sel = rand_addr_i + ADDR_WIDTH'(k);
        end
    end

    assign any_elig  = |elig;
    assign drain     = (state == FULL) && bus.fpu_req_ready_i[tgt];
    assign req_ready = !rst && any_elig && ((state == EMPTY) || drain);
    assign accept    = bus.req_valid_i && req_ready;

    assign lfsr_en_o           = accept;
    assign bus.req_ready_o     = req_ready;
    assign bus.fpu_req_valid_o = valid_q;
    assign bus.fpu_req_data_o  = data_q;

    always_comb begin
        inc = '0;
        if (accept)
            inc[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            tgt     <= '0;
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state   <= FULL;
                        tgt     <= sel;
                        data_q  <= bus.req_data_i;
                        valid_q <= ONE_HOT << sel;
                    end
                end
                FULL: begin
                    if (accept) begin
                        tgt     <= sel;
                        data_q  <= bus.req_data_i;
                        valid_q <= ONE_HOT << sel;
                    end else if (drain) begin
                        state   <= EMPTY;
                        valid_q <= '0;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= '0;
                end
            endcase
        end
    end

    // Credits are reserved at accept, so a staged request already counts as outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
            for (int i = 0; i < NB_FPU; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB_FPU; i++) begin
                if (bus.fpu_done_i[i] && (cnt[i] == '0))
                    err_o <= 1'b1;
                if (inc[i] && !bus.fpu_done_i[i])
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                else if (!inc[i] && bus.fpu_done_i[i] && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - CNT_WIDTH'(1);
            end
        end
    end

`ifdef FPU_RAND_DISPATCHER_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (bus.req_valid_i && !req_ready && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
